// File: rtl/time_counter.sv
// rtl/time_counter.sv - HH:MM:SS clock with a seconds prescaler and a SET mode driven by button edges.
// Time is held as four BCD digits plus binary seconds; set_mode is registered once to become the state.
module time_counter #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] first,
  output logic [3:0] second,
  output logic [3:0] third,
  output logic [3:0] fourth,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       min_tick
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic          min_hist;
  logic          hr_hist;
  logic          min_rise;
  logic          hr_rise;
  logic          last_tick;
  logic [3:0]    min_ones_inc;
  logic [3:0]    min_tens_inc;
  logic [3:0]    hr_ones_inc;
  logic [3:0]    hr_tens_inc;
  logic          min_wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = RUN;
    if (set_mode) state_next = SET;
  end

  assign min_rise  = inc_min & ~min_hist;
  assign hr_rise   = inc_hr & ~hr_hist;
  assign last_tick = (prescaler == PW'(TICKS_PER_SEC - 1));

  // Incremented digit values; min_wrap flags 59 -> 00 for the RUN-mode hour carry.
  always_comb begin
    min_wrap     = 1'b0;
    min_ones_inc = first + 4'd1;
    min_tens_inc = second;
    if (first == 4'd9) begin
      min_ones_inc = 4'd0;
      if (second == 4'd5) begin
        min_tens_inc = 4'd0;
        min_wrap     = 1'b1;
      end else begin
        min_tens_inc = second + 4'd1;
      end
    end
    hr_ones_inc = third + 4'd1;
    hr_tens_inc = fourth;
    if (fourth == 4'd2 && third == 4'd3) begin
      hr_ones_inc = 4'd0;
      hr_tens_inc = 4'd0;
    end else if (third == 4'd9) begin
      hr_ones_inc = 4'd0;
      hr_tens_inc = fourth + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first     <= 4'd0;
      second    <= 4'd0;
      third     <= 4'd0;
      fourth    <= 4'd0;
      seconds   <= 6'd0;
      prescaler <= '0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      min_hist  <= 1'b0;
      hr_hist   <= 1'b0;
    end else begin
      min_hist <= inc_min;
      hr_hist  <= inc_hr;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      // Entering, inside and leaving SET all hold the seconds chain at zero.
      if (state == SET || state_next == SET) begin
        prescaler <= '0;
        seconds   <= 6'd0;
        if (state == SET) begin
          if (min_rise) begin
            first  <= min_ones_inc;
            second <= min_tens_inc;
          end
          if (hr_rise) begin
            third  <= hr_ones_inc;
            fourth <= hr_tens_inc;
          end
        end
      end else if (last_tick) begin
        prescaler <= '0;
        sec_tick  <= 1'b1;
        if (seconds == 6'd59) begin
          seconds  <= 6'd0;
          min_tick <= 1'b1;
          first    <= min_ones_inc;
          second   <= min_tens_inc;
          if (min_wrap) begin
            third  <= hr_ones_inc;
            fourth <= hr_tens_inc;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100000000, meaning the number of clk cycles per second (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, meaning a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port set_mode, input, 1 bit, meaning the time-set switch level: 1 selects SET, 0 selects RUN.
REQ-005 The block SHALL have port inc_min, input, 1 bit, meaning the minute-increment button level, already synchronised to clk.
REQ-006 The block SHALL have port inc_hr, input, 1 bit, meaning the hour-increment button level, already synchronised to clk.
REQ-007 The block SHALL have port first, output, 4 bits, meaning the BCD minutes-ones digit, 0-9.
REQ-008 The block SHALL have port second, output, 4 bits, meaning the BCD minutes-tens digit, 0-5.
REQ-009 The block SHALL have port third, output, 4 bits, meaning the BCD hours-ones digit, 0-9 (0-3 when fourth=2).
REQ-010 The block SHALL have port fourth, output, 4 bits, meaning the BCD hours-tens digit, 0-2.
REQ-011 The block SHALL have port seconds, output, 6 bits, meaning binary seconds, 0-59.
REQ-012 The block SHALL have port sec_tick, output, 1 bit, meaning a one-cycle pulse on each seconds advance.
REQ-013 The block SHALL have port min_tick, output, 1 bit, meaning a one-cycle pulse on each RUN-mode minute rollover.

Function
REQ-014 The block SHALL have two states: RUN when registered set_mode=0, SET when registered set_mode=1; set_mode SHALL be registered once, and the state SHALL follow it one cycle later.
REQ-015 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1; on the edge where it equals TICKS_PER_SEC-1 it SHALL wrap to 0, seconds SHALL increment, and sec_tick SHALL be 1 for exactly that following cycle.
REQ-016 The first seconds increment after reset release SHALL occur exactly TICKS_PER_SEC cycles after the first edge with reset_n=1.
REQ-017 When seconds=59 advances, seconds SHALL become 0, minutes SHALL increment in BCD, and min_tick SHALL pulse concurrently with sec_tick.
REQ-018 Minute carry: first 9->0 SHALL increment second; second 5 with first 9 SHALL wrap to 00 and increment hours.
REQ-019 Hour carry: third 9->0 SHALL increment fourth; 23 SHALL wrap to 00; overall rollover 23:59:59 -> 00:00:00 SHALL occur in a single edge.
REQ-020 Entering SET SHALL clear the prescaler and seconds to 0; in SET, the prescaler, sec_tick and min_tick SHALL stay 0.
REQ-021 In SET, a rising edge on inc_min (detected against the previous-cycle value) SHALL increment minutes modulo 60 without carry into hours.
REQ-022 In SET, a rising edge on inc_hr SHALL increment hours modulo 24.
REQ-023 Simultaneous inc_min and inc_hr rising edges in the same cycle SHALL both apply in that cycle.
REQ-024 Held buttons SHALL produce exactly one increment per press; button edges in RUN SHALL be ignored.
REQ-025 Leaving SET SHALL restart counting from prescaler 0, seconds 0, preserving the set HH:MM.
REQ-026 Digit outputs SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-027 While reset_n=0 at a clk edge: first, second, third, fourth, seconds, prescaler SHALL become 0; sec_tick, min_tick SHALL be 0; state SHALL be RUN; button-edge history SHALL be 0.
REQ-028 Reset SHALL take priority over all other activity, including mid-count or mid-SET, and outputs SHALL be valid from the first edge after reset assertion.

Verification (TICKS_PER_SEC=4)
REQ-029 Bench SHALL check reset: hold reset_n=0 for 3 cycles -> all digits, seconds, and ticks are 0; first sec_tick occurs 4 cycles after release.
REQ-030 Bench SHALL check carry: set 09:59, then RUN for 60 s -> 10:00, min_tick coincident with the seconds 59->0 transition.
REQ-031 Bench SHALL check day wrap: set 23:59, then RUN 240 cycles -> 00:00:00 in one edge.
REQ-032 Bench SHALL check SET edges: at 12:59, inc_min held for 10 cycles -> 12:00 (single increment, no hour carry); an inc_hr press at 23 -> 00.
REQ-033 Bench SHALL check simultaneous presses: inc_min and inc_hr rise in the same cycle at 05:30 -> 06:31.
REQ-034 Bench SHALL check reset mid-operation: reset_n pulsed low for 1 cycle at 14:27:33 -> 00:00:00 on the next edge; the count then resumes normally.
